// File: rtl/re_name_retire.sv
// Commit-side rename bookkeeping: in-flight writer counters per renamed name,
// committed name-bit tables, issue stall and busy probe.
module re_name_retire #(
   parameter int NR_COMMIT_PORTS = 2,
   parameter int CNT_WIDTH       = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         issue_valid_i,
   input  logic                         issue_ack_i,
   input  logic [5:0]                   issue_rd_i,
   input  logic                         issue_rd_fpr_i,
   output logic                         issue_stall_o,
   input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
   input  logic [NR_COMMIT_PORTS*6-1:0] commit_rd_i,
   input  logic [NR_COMMIT_PORTS-1:0]   commit_rd_fpr_i,
   output logic [NR_COMMIT_PORTS*5-1:0] commit_arch_rd_o,
   input  logic [5:0]                   query_rd_i,
   input  logic                         query_rd_fpr_i,
   output logic                         query_busy_o,
   output logic [31:0]                  committed_gpr_o,
   output logic [31:0]                  committed_fpr_o,
   output logic                         underflow_o,
   output logic                         overflow_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Handshake: an issue is counted only when issue_valid_i & issue_ack_i in the
   // same cycle; issue_stall_o is advice to the acker and is not enforced here.
   logic                 issue_fire;
   logic [CNT_WIDTH-1:0] cnt_q [2][64];
   logic [CNT_WIDTH-1:0] cnt_d [2][64];
   logic [31:0]          tbl_q [2];
   logic [31:0]          tbl_d [2];
   logic                 unf_q, ovf_q, unf_set, ovf_set;

   assign issue_fire = issue_valid_i & issue_ack_i;

   always_comb begin
      int sum;
      sum     = 0;
      unf_set = 1'b0;
      ovf_set = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int n = 0; n < 64; n++) begin
            sum = int'(cnt_q[f][n]);
            // GPR x0 under either name bit is never tracked
            if (!(f == 0 && (n % 32) == 0)) begin
               if (issue_fire && issue_rd_fpr_i == 1'(f) && issue_rd_i == 6'(n))
                  sum = sum + 1;
               for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                  if (commit_valid_i[p] && commit_rd_fpr_i[p] == 1'(f) &&
                      commit_rd_i[p*6 +: 6] == 6'(n))
                     sum = sum - 1;
               end
            end
            if (sum < 0) begin
               unf_set     = 1'b1;
               cnt_d[f][n] = '0;
            end else if (sum > int'(CNT_MAX)) begin
               ovf_set     = 1'b1;
               cnt_d[f][n] = CNT_MAX;
            end else begin
               cnt_d[f][n] = CNT_WIDTH'(sum);
            end
         end
      end
      tbl_d = tbl_q;
      for (int f = 0; f < 2; f++) begin
         for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (commit_valid_i[p] && commit_rd_fpr_i[p] == 1'(f) &&
                !(f == 0 && commit_rd_i[p*6 +: 5] == 5'd0))
               tbl_d[f][commit_rd_i[p*6 +: 5]] = ~tbl_d[f][commit_rd_i[p*6 +: 5]];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 64; n++) cnt_q[f][n] <= '0;
            tbl_q[f] <= '0;
         end
         unf_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (flush_i) begin
         // error flags survive a flush; same-cycle events are dropped
         for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 64; n++) cnt_q[f][n] <= '0;
            tbl_q[f] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         tbl_q <= tbl_d;
         unf_q <= unf_q | unf_set;
         ovf_q <= ovf_q | ovf_set;
      end
   end

   assign issue_stall_o   = issue_valid_i & (cnt_q[issue_rd_fpr_i][issue_rd_i] == CNT_MAX);
   assign query_busy_o    = (cnt_q[query_rd_fpr_i][query_rd_i] != '0) &
                            ~(~query_rd_fpr_i & (query_rd_i[4:0] == 5'd0));
   assign committed_gpr_o = tbl_q[0];
   assign committed_fpr_o = tbl_q[1];
   assign underflow_o     = unf_q;
   assign overflow_o      = ovf_q;

   for (genvar p = 0; p < NR_COMMIT_PORTS; p++) begin : g_arch
      assign commit_arch_rd_o[p*5 +: 5] = commit_rd_i[p*6 +: 5];
   end

endmodule

// File: tb/tb_re_name_retire.sv
// Bench for re_name_retire: directed vector table, async reset check, and
// randomized traffic against a counting reference model.
module tb_re_name_retire;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, iv, ia, ifpr, qfpr;
   logic [5:0]  ird, qrd;
   logic [1:0]  cv, cf;
   logic [11:0] crd;
   logic        stall, busy, unf, ovf;
   logic [9:0]  arch;
   logic [31:0] gpr, fpr;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          mcnt [2][64];
   logic [31:0] mtbl [2];
   bit          munf, movf;

   logic [77:0] exp_q [$];

   typedef struct {
      logic flush, iv, ia; logic [5:0] ird; logic ifpr;
      logic [1:0] cv; logic [5:0] c0, c1; logic [1:0] cf;
      logic [5:0] qrd; logic qfpr;
      logic e_stall, e_busy; logic [31:0] e_gpr, e_fpr; logic [9:0] e_arch;
      logic e_unf, e_ovf;
   } vec_t;

   vec_t vecs [$];

   re_name_retire #(.NR_COMMIT_PORTS(2), .CNT_WIDTH(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .issue_valid_i(iv), .issue_ack_i(ia), .issue_rd_i(ird), .issue_rd_fpr_i(ifpr),
      .issue_stall_o(stall),
      .commit_valid_i(cv), .commit_rd_i(crd), .commit_rd_fpr_i(cf),
      .commit_arch_rd_o(arch),
      .query_rd_i(qrd), .query_rd_fpr_i(qfpr), .query_busy_o(busy),
      .committed_gpr_o(gpr), .committed_fpr_o(fpr),
      .underflow_o(unf), .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic fl, logic v, logic a, logic [5:0] rd, logic f,
                               logic [1:0] c_v, logic [5:0] c0, logic [5:0] c1, logic [1:0] c_f,
                               logic [5:0] q, logic qf, logic es, logic eb,
                               logic [31:0] eg, logic [31:0] ef, logic [9:0] ea,
                               logic eu, logic eo);
      vec_t r;
      r.flush = fl; r.iv = v; r.ia = a; r.ird = rd; r.ifpr = f;
      r.cv = c_v; r.c0 = c0; r.c1 = c1; r.cf = c_f; r.qrd = q; r.qfpr = qf;
      r.e_stall = es; r.e_busy = eb; r.e_gpr = eg; r.e_fpr = ef; r.e_arch = ea;
      r.e_unf = eu; r.e_ovf = eo;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      flush = v.flush; iv = v.iv; ia = v.ia; ird = v.ird; ifpr = v.ifpr;
      cv = v.cv; crd = {v.c1, v.c0}; cf = v.cf; qrd = v.qrd; qfpr = v.qfpr;
      #1;
   endtask

   task automatic model_reset();
      for (int f = 0; f < 2; f++) begin
         for (int n = 0; n < 64; n++) mcnt[f][n] = 0;
         mtbl[f] = '0;
      end
      munf = 0; movf = 0;
   endtask

   // one cycle of retirement bookkeeping from the current tb inputs
   task automatic model_update();
      int d [2][64];
      logic [5:0] c;
      int v;
      if (flush) begin
         for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < 64; n++) mcnt[f][n] = 0;
            mtbl[f] = '0;
         end
         return;
      end
      for (int f = 0; f < 2; f++) for (int n = 0; n < 64; n++) d[f][n] = 0;
      if (iv && ia && !(ifpr == 1'b0 && ird[4:0] == 5'd0)) d[ifpr][ird] += 1;
      for (int p = 0; p < 2; p++) begin
         c = crd[p*6 +: 6];
         if (cv[p] && !(cf[p] == 1'b0 && c[4:0] == 5'd0)) begin
            d[cf[p]][c] -= 1;
            mtbl[cf[p]][c[4:0]] = ~mtbl[cf[p]][c[4:0]];
         end
      end
      for (int f = 0; f < 2; f++) begin
         for (int n = 0; n < 64; n++) begin
            v = mcnt[f][n] + d[f][n];
            if (v < 0) begin v = 0; munf = 1; end
            else if (v > 7) begin v = 7; movf = 1; end
            mcnt[f][n] = v;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      vec_t v;
      logic [77:0] e;
      rst_n = 1'b0;
      drive(mk(0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0));
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_gpr", gpr, 0);
      chk("reset_fpr", fpr, 0);
      chk("reset_flags", {30'd0, unf, ovf}, 0);
      rst_n = 1'b1;

      // flush,iv,ia,ird,ifpr, cv,c0,c1,cf, qrd,qfpr, stall,busy,gpr,fpr,arch,unf,ovf
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,32'h000,0,10'h000,0,0));
      vecs.push_back(mk(0,1,1,6'h25,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,32'h000,0,10'h000,0,0));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,1,32'h000,0,10'h000,0,0));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h05,0, 0,0,32'h000,0,10'h000,0,0));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b01,6'h25,6'h00,2'b00, 6'h25,0, 0,1,32'h000,0,10'h005,0,0));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,32'h020,0,10'h000,0,0));
      for (int i = 0; i < 7; i++)
         vecs.push_back(mk(0,1,1,6'h03,1, 2'b00,6'h00,6'h00,2'b00, 6'h03,1, 0,(i > 0),32'h020,0,10'h000,0,0));
      vecs.push_back(mk(0,1,0,6'h03,1, 2'b00,6'h00,6'h00,2'b00, 6'h03,1, 1,1,32'h020,0,10'h000,0,0));
      vecs.push_back(mk(0,1,1,6'h03,1, 2'b00,6'h00,6'h00,2'b00, 6'h03,1, 1,1,32'h020,0,10'h000,0,0));
      vecs.push_back(mk(0,1,0,6'h03,1, 2'b00,6'h00,6'h00,2'b00, 6'h03,1, 1,1,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,1,1,6'h29,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,0,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,1,1,6'h29,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,1,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b11,6'h29,6'h29,2'b00, 6'h29,0, 0,1,32'h020,0,10'h129,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,0,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,1,1,6'h29,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,0,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,1,1,6'h29,0, 2'b01,6'h29,6'h00,2'b00, 6'h29,0, 0,1,32'h020,0,10'h009,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,1,32'h220,0,10'h000,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b10,6'h00,6'h29,2'b00, 6'h29,0, 0,1,32'h220,0,10'h120,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h29,0, 0,0,32'h020,0,10'h000,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b01,6'h2A,6'h00,2'b00, 6'h2A,0, 0,0,32'h020,0,10'h00A,0,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h2A,0, 0,0,32'h420,0,10'h000,1,1));
      vecs.push_back(mk(0,1,1,6'h20,0, 2'b11,6'h00,6'h20,2'b00, 6'h20,0, 0,0,32'h420,0,10'h000,1,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h20,0, 0,0,32'h420,0,10'h000,1,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h00,0, 0,0,32'h420,0,10'h000,1,1));
      vecs.push_back(mk(0,1,1,6'h25,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,32'h420,0,10'h000,1,1));
      vecs.push_back(mk(0,1,1,6'h07,1, 2'b10,6'h00,6'h03,2'b10, 6'h07,1, 0,0,32'h420,0,10'h060,1,1));
      vecs.push_back(mk(1,1,1,6'h25,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,1,32'h420,32'h8,10'h000,1,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,32'h000,0,10'h000,1,1));
      vecs.push_back(mk(0,1,0,6'h03,1, 2'b00,6'h00,6'h00,2'b00, 6'h03,1, 0,0,32'h000,0,10'h000,1,1));
      vecs.push_back(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h07,1, 0,0,32'h000,0,10'h000,1,1));

      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v);
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(v.e_stall));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.e_busy));
         chk($sformatf("v%0d_gpr", i), gpr, v.e_gpr);
         chk($sformatf("v%0d_fpr", i), fpr, v.e_fpr);
         chk($sformatf("v%0d_arch", i), 32'(arch), 32'(v.e_arch));
         chk($sformatf("v%0d_unf", i), 32'(unf), 32'(v.e_unf));
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(v.e_ovf));
         step();
      end

      // asynchronous reset in the middle of activity, away from any clock edge
      drive(mk(0,1,1,6'h25,0, 2'b01,6'h0B,6'h00,2'b00, 6'h25,0, 0,0,0,0,10'h00B,0,0));
      step();
      drive(mk(0,0,0,6'h00,0, 2'b00,6'h00,6'h00,2'b00, 6'h25,0, 0,0,0,0,0,0,0));
      chk("pre_rst_busy", 32'(busy), 1);
      chk("pre_rst_gpr", gpr, 32'h800);
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_gpr", gpr, 0);
      chk("async_rst_flags", {30'd0, unf, ovf}, 0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic on a few colliding names, including x0
      for (int i = 0; i < 500; i++) begin
         flush = ($urandom_range(0, 39) == 0);
         iv    = ($urandom_range(0, 3) != 0);
         ifpr  = 1'($urandom);
         ird   = {1'($urandom), 5'($urandom_range(0, 3))};
         if (iv && mcnt[ifpr][ird] == 7) ia = ($urandom_range(0, 7) == 0);
         else ia = iv & ($urandom_range(0, 3) != 0);
         for (int p = 0; p < 2; p++) begin
            cv[p] = ($urandom_range(0, 2) == 0);
            cf[p] = 1'($urandom);
            crd[p*6 +: 6] = {1'($urandom), 5'($urandom_range(0, 3))};
         end
         qfpr = 1'($urandom);
         qrd  = {1'($urandom), 5'($urandom_range(0, 3))};
         #1;
         exp_q.push_back({(iv && mcnt[ifpr][ird] == 7), (mcnt[qfpr][qrd] != 0),
                          munf, movf, mtbl[0], mtbl[1], crd[10:6], crd[4:0]});
         e = exp_q.pop_front();
         chk($sformatf("r%0d_stall", i), 32'(stall), 32'(e[77]));
         chk($sformatf("r%0d_busy", i), 32'(busy), 32'(e[76]));
         chk($sformatf("r%0d_unf", i), 32'(unf), 32'(e[75]));
         chk($sformatf("r%0d_ovf", i), 32'(ovf), 32'(e[74]));
         chk($sformatf("r%0d_gpr", i), gpr, e[73:42]);
         chk($sformatf("r%0d_fpr", i), fpr, e[41:10]);
         chk($sformatf("r%0d_arch", i), 32'(arch), 32'(e[9:0]));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/re_name_retire.md
Name: re_name_retire

Overview:
- Commit-side counterpart of the register re-naming stage.
- Tracks how many in-flight writers target each renamed destination name: 1 name bit + 5 address bits, for both the GPR and FPR files.
- Keeps the committed (architectural) name-bit tables, which are toggled only on retirement.
- Provides a stall to the rename/issue path when a name's writer counter is saturated, and busy information for any queried renamed register.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports retiring in one cycle.
- CNT_WIDTH, 3, width of each in-flight writer counter; maximum count is 2^CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  flush all renaming/retire state.
- issue_valid_i  in  1  a renamed instruction is handed to issue.
- issue_ack_i  in  1  issue accepted the instruction.
- issue_rd_i  in  6  renamed destination {name bit, addr[4:0]}.
- issue_rd_fpr_i  in  1  destination is in the FP register file.
- issue_stall_o  out  1  the target name's counter is saturated; issue must not ack.
- commit_valid_i  in  NR_COMMIT_PORTS  per-port instruction retiring.
- commit_rd_i  in  NR_COMMIT_PORTS*6  per-port renamed destination.
- commit_rd_fpr_i  in  NR_COMMIT_PORTS  per-port FP destination flag.
- commit_arch_rd_o  out  NR_COMMIT_PORTS*5  per-port architectural rd, i.e. commit_rd_i[4:0].
- query_rd_i  in  6  renamed register to probe.
- query_rd_fpr_i  in  1  probe targets the FP file.
- query_busy_o  out  1  the probed name has at least one in-flight writer.
- committed_gpr_o  out  32  committed name-bit table, GPR.
- committed_fpr_o  out  32  committed name-bit table, FPR.
- underflow_o  out  1  sticky error flag: a commit hit a zero counter.
- overflow_o  out  1  sticky error flag: an issue hit a saturated counter.

Behaviour:
- State:
  - Counter arrays cnt_gpr[64] and cnt_fpr[64], each CNT_WIDTH bits.
  - Committed tables committed_gpr and committed_fpr, 32 bits each.
  - Sticky flags underflow and overflow.
  - Reset value of all state is 0, so every output is 0 at reset.
- Issue event:
  - Occurs when issue_valid_i & issue_ack_i.
  - Increments the counter of the target name.
  - GPR name with addr 0 (both name bits) is never counted; x0 is ignored.
- Commit event on port p:
  - Occurs when commit_valid_i[p].
  - Decrements the counter of that port's name.
  - Toggles committed_{gpr|fpr}[addr]; the GPR addr-0 entry is never toggled and stays 0.
- Same-cycle arithmetic:
  - All events of one cycle are summed per name: next = cnt + issue_hit - number of commit ports hitting that name.
  - Two commit ports on the same name decrement by 2 and toggle the committed bit twice (net no change).
  - Issue and commit on the same name in one cycle leave the counter unchanged.
- Saturation and errors:
  - A decrement below 0 clamps to 0 and sets underflow_o.
  - An increment above the maximum clamps at the maximum and sets overflow_o.
  - Both flags are cleared only by reset, not by flush.
- issue_stall_o:
  - Combinational from the current counter: issue_valid_i & (cnt[issue_rd_i] == max).
  - Stall does not look at same-cycle commits; conservative by one cycle.
- query_busy_o:
  - Combinational from registered state only: cnt[query] != 0.
  - An issue or commit in cycle N becomes visible in cycle N+1.
  - A GPR query with addr 0 always returns 0.
- commit_arch_rd_o is purely combinational, with no state.
- Flush:
  - flush_i clears all counters and both committed tables next cycle, keeping them aligned with the rename stage, which also clears its table.
  - Flush has priority over same-cycle issue and commit events.
- Reset mid-operation:
  - Asynchronous reset returns all state to 0 immediately; no drain is required.

Test Plan:
- Reset, then issue GPR rd={1,5} (acked) -> query {1,5} busy=1 at the next cycle; query {0,5} busy=0; committed_gpr_o=0.
- After that issue, commit port 0 with rd={1,5} -> counter 0, busy=0 next cycle, committed_gpr_o[5]=1, commit_arch_rd_o[0]=5.
- Issue FPR rd={0,3} seven times with CNT_WIDTH=3 -> issue_stall_o=1 on the next attempt; forcing an acked issue anyway sets overflow_o=1 and the counter stays 7.
- Counter at 2 for GPR {1,9}, with both commit ports retiring {1,9} in the same cycle -> counter 0, committed_gpr_o[9] unchanged. In another cycle, same-cycle issue plus commit on one name -> counter unchanged.
- Commit with zero count, and issue/commit of GPR x0 -> underflow_o=1 and sticky for the zero-count commit; x0 counter and committed bit stay 0.
- Several names busy, then flush_i together with an issue -> all counters and tables 0 next cycle; the issue is discarded; error flags are kept.
